// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between two byte sources.
// Launches a byte with a one-cycle send_en, waits for tx_done, and abandons it on watchdog expiry.
module uart_tx_arbiter #(
    parameter int TIMEOUT = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       gnt0,
    output logic       done0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt1,
    output logic       done1,
    output logic [7:0] tx_data,
    output logic       send_en,
    input  logic       tx_done,
    output logic       busy,
    output logic       timeout_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] tx_data_q, tx_data_d;
    logic       send_en_q, send_en_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       timeout_err_q, timeout_err_d;
    logic       busy_q, busy_d;

    logic any_req;
    logic sel;
    logic wd_expired;

    // On a tie the requester that did not win last time is chosen.
    assign any_req    = req0 | req1;
    assign sel        = (req0 & req1) ? ~last_grant_q : req1;
    assign wd_expired = (cnt_q == CNT_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            cnt_q         <= '0;
            tx_data_q     <= 8'h00;
            send_en_q     <= 1'b0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            send_en_q     <= send_en_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d      = ST_SEND;
                    owner_d      = sel;
                    last_grant_d = sel;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                if (tx_done || wd_expired) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // tx_done beats the watchdog when both land in the same WAIT cycle.
    always_comb begin
        tx_data_d     = tx_data_q;
        send_en_d     = 1'b0;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        timeout_err_d = 1'b0;
        busy_d        = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    tx_data_d = sel ? data1 : data0;
                    send_en_d = 1'b1;
                    gnt0_d    = ~sel;
                    gnt1_d    = sel;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                end else if (wd_expired) begin
                    timeout_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign tx_data     = tx_data_q;
    assign send_en     = send_en_q;
    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected launch/done/timeout events with
// their cycle numbers, a negedge monitor pops and compares whenever the DUT emits one.
module tb_uart_tx_arbiter;

    typedef enum logic [1:0] {EV_LAUNCH, EV_DONE, EV_TIMEOUT} ev_e;
    typedef struct {
        ev_e        kind;
        logic       owner;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1, done0, done1;
    logic [7:0] tx_data;
    logic       send_en, tx_done, busy, timeout_err;

    int  checks;
    int  errors;
    int  cyc;
    logic prev_send;
    ev_t exp_q[$];

    uart_tx_arbiter #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .data0      (data0),
        .gnt0       (gnt0),
        .done0      (done0),
        .req1       (req1),
        .data1      (data1),
        .gnt1       (gnt1),
        .done1      (done1),
        .tx_data    (tx_data),
        .send_en    (send_en),
        .tx_done    (tx_done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input ev_e k, input logic o, input logic [7:0] d, input int c);
        ev_t e;
        e.kind  = k;
        e.owner = o;
        e.data  = d;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge of cycle c: tx_done is high in cycle c, low again from c+1.
    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_data"}, int'(tx_data), 0);
        check({tag, "_send_en"}, int'(send_en), 0);
        check({tag, "_gnt"}, int'({gnt1, gnt0}), 0);
        check({tag, "_done"}, int'({done1, done0}), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_timeout_err"}, int'(timeout_err), 0);
    endtask

    // Monitor: pops one expectation for every launch, done or timeout the DUT presents.
    always @(negedge clk) begin : monitor
        ev_t e;
        ev_e act_kind;
        if (rst_n) begin
            if (gnt0 || gnt1) check("gnt_with_send_en", int'(send_en), 1);
            if (send_en) check("send_en_single_cycle", int'(prev_send), 0);
            if (timeout_err) check("timeout_without_done", int'({done1, done0}), 0);
            if (send_en || done0 || done1 || timeout_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", int'({send_en, done1, done0, timeout_err}), 0);
                end else begin
                    e = exp_q.pop_front();
                    act_kind = send_en ? EV_LAUNCH : (timeout_err ? EV_TIMEOUT : EV_DONE);
                    check("event_kind", int'(act_kind), int'(e.kind));
                    check("event_cycle", cyc, e.cyc);
                    if (send_en) begin
                        check("gnt_owner", int'({gnt1, gnt0}), e.owner ? 2 : 1);
                        check("tx_data", int'(tx_data), int'(e.data));
                    end else if (done0 || done1) begin
                        check("done_owner", int'({done1, done0}), e.owner ? 2 : 1);
                    end
                end
            end
        end
        prev_send <= send_en && rst_n;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int t;
        int r;
        logic o;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        req0    = 1'b0;
        req1    = 1'b0;
        data0   = 8'h00;
        data1   = 8'h00;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single request; tx_done 10 cycles after send_en.
        t = cyc;
        data0 = 8'h55;
        req0  = 1'b1;
        expect_ev(EV_LAUNCH, 1'b0, 8'h55, t + 1);
        wait_until(t + 1);
        req0 = 1'b0;
        wait_until(t + 5);
        check("t1_busy_in_wait", int'(busy), 1);
        wait_until(t + 11);
        expect_ev(EV_DONE, 1'b0, 8'h00, t + 12);
        pulse_tx_done();
        check("t1_busy_after_done", int'(busy), 0);
        @(negedge clk);

        // Simultaneous requests right after reset: requester 0 wins the first tie.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        t = cyc;
        data0 = 8'hA1;
        data1 = 8'hB2;
        req0  = 1'b1;
        req1  = 1'b1;
        expect_ev(EV_LAUNCH, 1'b0, 8'hA1, t + 1);
        wait_until(t + 1);
        req0 = 1'b0;
        wait_until(t + 5);
        expect_ev(EV_DONE, 1'b0, 8'h00, t + 6);
        expect_ev(EV_LAUNCH, 1'b1, 8'hB2, t + 7);
        pulse_tx_done();
        wait_until(t + 7);
        req1 = 1'b0;
        wait_until(t + 9);
        expect_ev(EV_DONE, 1'b1, 8'h00, t + 10);
        pulse_tx_done();
        @(negedge clk);

        // Continuous load: both re-request after every done; order 0,1,0,1,0,1.
        t = cyc;
        data0 = 8'h10;
        data1 = 8'h20;
        req0  = 1'b1;
        req1  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            o = i[0];
            expect_ev(EV_LAUNCH, o, o ? data1 : data0, t + 1);
            wait_until(t + 1);
            if (o) req1 = 1'b0;
            else   req0 = 1'b0;
            wait_until(t + 3);
            expect_ev(EV_DONE, o, 8'h00, t + 4);
            pulse_tx_done();
            if (i == 5) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end else if (o) begin
                data1 = 8'h20 + 8'(i + 1);
                req1  = 1'b1;
            end else begin
                data0 = 8'h10 + 8'(i + 1);
                req0  = 1'b1;
            end
            t = t + 4;
        end
        @(negedge clk);

        // Watchdog: no tx_done, timeout_err 17 cycles after send_en, then a normal grant.
        t = cyc;
        data1 = 8'h3C;
        req1  = 1'b1;
        expect_ev(EV_LAUNCH, 1'b1, 8'h3C, t + 1);
        expect_ev(EV_TIMEOUT, 1'b1, 8'h00, t + 18);
        wait_until(t + 1);
        req1 = 1'b0;
        wait_until(t + 17);
        check("t4_busy_before_timeout", int'(busy), 1);
        wait_until(t + 18);
        check("t4_busy_at_timeout", int'(busy), 0);
        data0 = 8'hC3;
        req0  = 1'b1;
        expect_ev(EV_LAUNCH, 1'b0, 8'hC3, t + 19);
        wait_until(t + 19);
        req0 = 1'b0;
        wait_until(t + 21);
        expect_ev(EV_DONE, 1'b0, 8'h00, t + 22);
        pulse_tx_done();
        @(negedge clk);

        // Spurious tx_done in IDLE and in SEND: both ignored.
        t = cyc;
        pulse_tx_done();
        data1 = 8'h99;
        req1  = 1'b1;
        expect_ev(EV_LAUNCH, 1'b1, 8'h99, t + 2);
        wait_until(t + 2);
        req1 = 1'b0;
        pulse_tx_done();
        wait_until(t + 7);
        expect_ev(EV_DONE, 1'b1, 8'h00, t + 8);
        pulse_tx_done();
        @(negedge clk);

        // tx_done coincident with counter == TIMEOUT-1: done only.
        t = cyc;
        data0 = 8'h5A;
        req0  = 1'b1;
        expect_ev(EV_LAUNCH, 1'b0, 8'h5A, t + 1);
        wait_until(t + 1);
        req0 = 1'b0;
        wait_until(t + 17);
        expect_ev(EV_DONE, 1'b0, 8'h00, t + 18);
        pulse_tx_done();
        check("t5_busy_after_boundary_done", int'(busy), 0);
        @(negedge clk);

        // Reset 3 cycles after send_en with req0 held; byte is dropped, then relaunched.
        t = cyc;
        data0 = 8'h7E;
        req0  = 1'b1;
        expect_ev(EV_LAUNCH, 1'b0, 8'h7E, t + 1);
        wait_until(t + 4);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_reset_async");
        repeat (3) @(negedge clk);
        check_idle_outputs("t6_reset_held");
        rst_n = 1'b1;
        r = cyc;
        expect_ev(EV_LAUNCH, 1'b0, 8'h7E, r + 1);
        wait_until(r + 1);
        req0 = 1'b0;
        wait_until(r + 3);
        expect_ev(EV_DONE, 1'b0, 8'h00, r + 4);
        pulse_tx_done();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
